// File: rtl/tug_scorer.sv
// Round scorer and LED driver for the tug-of-war datapath.
// Tracks the rope position, decides normal and speed rounds, and renders
// the LED bar for whatever display code the master controller selects.
module tug_scorer #(
    parameter int NPOS         = 9,
    parameter int POS_W        = 4,
    parameter int SPEED_TARGET = 10,
    parameter int SPD_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pbl,
    input  logic             pbr,
    input  logic             clear,
    input  logic             leds_on,
    input  logic             fake,
    input  logic             speed_round,
    input  logic [2:0]       led_control,
    output logic             winrnd,
    output logic             winspeed,
    output logic             match_over,
    output logic [POS_W-1:0] position,
    output logic [NPOS-1:0]  leds
);

    localparam int                CTR     = (NPOS - 1) / 2;
    localparam logic [POS_W-1:0]  CTR_POS = POS_W'(CTR);
    localparam logic [POS_W-1:0]  MAX_POS = POS_W'(NPOS - 1);
    localparam logic [SPD_W-1:0]  TARGET  = SPD_W'(SPEED_TARGET);
    localparam logic [SPD_W-1:0]  ONE_SPD = SPD_W'(1);
    localparam logic signed [POS_W+1:0] MAX_SUM = (POS_W+2)'(NPOS - 1);
    localparam logic signed [POS_W+1:0] STEP_UP = (POS_W+2)'(1);
    localparam logic signed [POS_W+1:0] STEP_DN = -(POS_W+2)'(1);

    logic [POS_W-1:0] position_q, position_d;
    logic             winrnd_q, winrnd_d;
    logic             winspeed_q, winspeed_d;
    logic             speed_winner_q, speed_winner_d;
    logic [SPD_W-1:0] cntl_q, cntl_d;
    logic [SPD_W-1:0] cntr_q, cntr_d;
    logic [NPOS-1:0]  leds_q, leds_d;

    logic                    normal_active;
    logic                    fair;
    logic                    inc_l, inc_r;
    logic                    hit_l, hit_r;
    logic signed [POS_W+1:0] norm_step;
    logic signed [POS_W+1:0] spd_step;
    logic signed [POS_W+1:0] pos_sum;

    assign match_over = (position_q == '0) || (position_q == MAX_POS);
    assign position   = position_q;
    assign winrnd     = winrnd_q;
    assign winspeed   = winspeed_q;
    assign leds       = leds_q;

    // Normal round: judge the first press of the round and latch the decision
    always_comb begin
        normal_active = !clear && !winrnd_q;
        fair          = leds_on && !fake;
        norm_step     = '0;
        if (normal_active && pbl && !pbr) begin
            norm_step = fair ? STEP_UP : STEP_DN;
        end else if (normal_active && pbr && !pbl) begin
            norm_step = fair ? STEP_DN : STEP_UP;
        end
        winrnd_d = winrnd_q;
        if (clear) begin
            winrnd_d = 1'b0;
        end else if (normal_active && (pbl || pbr)) begin
            winrnd_d = 1'b1;
        end
    end

    // Speed round: count presses per side and declare the first to reach target
    always_comb begin
        cntl_d         = cntl_q;
        cntr_d         = cntr_q;
        winspeed_d     = winspeed_q;
        speed_winner_d = speed_winner_q;
        spd_step       = '0;
        inc_l          = 1'b0;
        inc_r          = 1'b0;
        hit_l          = 1'b0;
        hit_r          = 1'b0;
        if (!speed_round) begin
            cntl_d     = '0;
            cntr_d     = '0;
            winspeed_d = 1'b0;
        end else if (!winspeed_q) begin
            inc_l = pbl && (cntl_q != TARGET);
            inc_r = pbr && (cntr_q != TARGET);
            hit_l = inc_l && (cntl_q == TARGET - ONE_SPD);
            hit_r = inc_r && (cntr_q == TARGET - ONE_SPD);
            if (inc_l) begin
                cntl_d = cntl_q + ONE_SPD;
            end
            if (inc_r) begin
                cntr_d = cntr_q + ONE_SPD;
            end
            if (hit_l || hit_r) begin
                winspeed_d = 1'b1;
            end
            if (hit_l && !hit_r) begin
                speed_winner_d = 1'b1;
                spd_step       = STEP_UP;
            end else if (hit_r && !hit_l) begin
                speed_winner_d = 1'b0;
                spd_step       = STEP_DN;
            end
        end
    end

    // Rope position: restart to centre, or apply both step sources with saturation
    always_comb begin
        pos_sum    = $signed({2'b00, position_q}) + norm_step + spd_step;
        position_d = position_q;
        if (clear && (led_control == 3'b010) && match_over) begin
            position_d = CTR_POS;
        end else if (!match_over) begin
            if (pos_sum[POS_W+1]) begin
                position_d = '0;
            end else if (pos_sum > MAX_SUM) begin
                position_d = MAX_POS;
            end else begin
                position_d = pos_sum[POS_W-1:0];
            end
        end
    end

    // LED bar decode from the display code and the current scoring state
    always_comb begin
        leds_d = '0;
        if (leds_on) begin
            case (led_control)
                3'b001:  leds_d[CTR] = 1'b1;
                3'b010:  leds_d = '1;
                3'b011:  leds_d[position_q] = 1'b1;
                3'b100:  leds_d[MAX_POS - position_q] = 1'b1;
                3'b110: begin
                    for (int i = 0; i < NPOS; i++) begin
                        leds_d[i] = (i == CTR) || (speed_winner_q ? (i > CTR) : (i < CTR));
                    end
                end
                default: leds_d = '0;
            endcase
        end
    end

    // State registers with asynchronous reset back to the idle match state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            position_q     <= CTR_POS;
            winrnd_q       <= 1'b0;
            winspeed_q     <= 1'b0;
            speed_winner_q <= 1'b0;
            cntl_q         <= '0;
            cntr_q         <= '0;
            leds_q         <= '0;
        end else begin
            position_q     <= position_d;
            winrnd_q       <= winrnd_d;
            winspeed_q     <= winspeed_d;
            speed_winner_q <= speed_winner_d;
            cntl_q         <= cntl_d;
            cntr_q         <= cntr_d;
            leds_q         <= leds_d;
        end
    end

endmodule
